// File: rtl/puf_ctrl_pkg.sv
// Shared types and default timing for the PDL race-PUF sequencer.
// Holds the FSM state enum and the counter-width helper used by the top and vote counters.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONFIG,
        LAUNCH,
        SAMPLE,
        RELAX,
        VOTE,
        DONE
    } puf_state_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CHAL_WIDTH = 64;
    localparam int DEF_N_TRIALS   = 15;
    localparam int DEF_CFG_SETTLE = 8;
    localparam int DEF_RACE_WAIT  = 16;
    localparam int DEF_RELAX_WAIT = 8;

    // Bits needed to hold values 0..n inclusive.
    function automatic int CNT_W(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/puf_vote_counter.sv
// Per-bit capture path: 2-flop synchronizer, one-counter and majority/unstable comparators.
// The unstable flag exists only when PUF_MAJORITY_VOTE_EN is defined; otherwise it is tied low.
module puf_vote_counter
    import puf_ctrl_pkg::*;
#(
    parameter int N_TRIALS = DEF_N_TRIALS
)(
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic sample,
    input  logic vote,
    input  logic latch_bit,
    output logic resp,
    output logic unstable
);

    localparam int CW = CNT_W(N_TRIALS);
    localparam logic [CW-1:0] HALF = CW'(N_TRIALS / 2);

    logic [1:0]    sync_q;
    logic [CW-1:0] ones;

    // Count cannot exceed N_TRIALS, so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            ones   <= '0;
            resp   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], latch_bit};
            if (clear) begin
                ones <= '0;
            end else if (sample && sync_q[1]) begin
                ones <= ones + CW'(1);
            end
            if (vote) begin
                resp <= (ones > HALF);
            end
        end
    end

`ifdef PUF_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] FULL = CW'(N_TRIALS);

    always_ff @(posedge clk) begin
        if (rst) begin
            unstable <= 1'b0;
        end else if (vote) begin
            unstable <= (ones != '0) && (ones != FULL);
        end
    end
`else
    assign unstable = 1'b0;
`endif

endmodule

// File: rtl/puf_race_ctrl.sv
// Race sequencer for the 32-bit PDL PUF capture array: FSM, wait timer and per-bit vote counters.
// Define PUF_MAJORITY_VOTE_EN for N_TRIALS voted races; otherwise a single race per challenge.
//
// state  | meaning
// IDLE   | waiting for start; pdl_cfg holds last challenge
// CONFIG | PDL select bits settling, launch low
// LAUNCH | launch high, race in flight
// SAMPLE | launch still high, synchronized capture counted
// RELAX  | launch low between races
// VOTE   | majority / unstable words registered
// DONE   | resp_valid pulse
module puf_race_ctrl
    import puf_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHAL_WIDTH = DEF_CHAL_WIDTH,
    parameter int N_TRIALS   = DEF_N_TRIALS,
    parameter int CFG_SETTLE = DEF_CFG_SETTLE,
    parameter int RACE_WAIT  = DEF_RACE_WAIT,
    parameter int RELAX_WAIT = DEF_RELAX_WAIT
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CHAL_WIDTH-1:0] challenge,
    output logic                  busy,
    output logic [CHAL_WIDTH-1:0] pdl_cfg,
    output logic                  launch,
    input  logic [DATA_WIDTH-1:0] latch_q,
    output logic [DATA_WIDTH-1:0] resp,
    output logic [DATA_WIDTH-1:0] unstable,
    output logic                  resp_valid
);

`ifdef PUF_MAJORITY_VOTE_EN
    localparam bit VOTE_EN = 1'b1;
`else
    localparam bit VOTE_EN = 1'b0;
`endif

    localparam int NT   = VOTE_EN ? N_TRIALS : 1;
    localparam int CW   = CNT_W(NT);
    localparam int TMAX = (CFG_SETTLE > RACE_WAIT)
                        ? ((CFG_SETTLE > RELAX_WAIT) ? CFG_SETTLE : RELAX_WAIT)
                        : ((RACE_WAIT > RELAX_WAIT) ? RACE_WAIT : RELAX_WAIT);
    localparam int TW   = CNT_W(TMAX);

    localparam logic [TW-1:0] T_CFG   = TW'(CFG_SETTLE - 1);
    localparam logic [TW-1:0] T_RACE  = TW'(RACE_WAIT - 1);
    localparam logic [TW-1:0] T_RELAX = TW'(RELAX_WAIT - 1);
    localparam logic [CW-1:0] NT_C    = CW'(NT);

    puf_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] trial_q, trial_d;
    logic          accept, clear, sample, vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            timer_q <= '0;
            trial_q <= '0;
            pdl_cfg <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            trial_q <= trial_d;
            if (accept) begin
                pdl_cfg <= challenge;
            end
        end
    end

    // Wait states use a down-counter loaded on entry and leave on terminal count.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        trial_d = trial_q;
        accept  = 1'b0;
        clear   = 1'b0;
        sample  = 1'b0;
        vote    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    clear   = 1'b1;
                    trial_d = '0;
                    timer_d = T_CFG;
                    state_d = CONFIG;
                end
            end
            CONFIG: begin
                if (timer_q == '0) begin
                    timer_d = T_RACE;
                    state_d = LAUNCH;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            LAUNCH: begin
                if (timer_q == '0) begin
                    state_d = SAMPLE;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            SAMPLE: begin
                sample  = 1'b1;
                trial_d = trial_q + CW'(1);
                timer_d = T_RELAX;
                state_d = RELAX;
            end
            RELAX: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else if (trial_q < NT_C) begin
                    timer_d = T_RACE;
                    state_d = LAUNCH;
                end else begin
                    state_d = VOTE;
                end
            end
            VOTE: begin
                vote    = 1'b1;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign launch     = (state_q == LAUNCH) || (state_q == SAMPLE);
    assign resp_valid = (state_q == DONE);

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
        puf_vote_counter #(
            .N_TRIALS (NT)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .clear     (clear),
            .sample    (sample),
            .vote      (vote),
            .latch_bit (latch_q[i]),
            .resp      (resp[i]),
            .unstable  (unstable[i])
        );
    end

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Self-checking bench for puf_race_ctrl: table vectors, randomized trials against a
// per-bit ones-count model, and hand-written start-while-busy / reset-mid-race sequences.
`timescale 1ns/1ps
module tb_puf_race_ctrl;

    localparam int DW    = 32;
    localparam int CHW   = 64;
    localparam int NTR   = 15;
    localparam int CFG   = 8;
    localparam int RACE  = 16;
    localparam int RELAX = 8;
`ifdef PUF_MAJORITY_VOTE_EN
    localparam int NT = NTR;
`else
    localparam int NT = 1;
`endif
    localparam int PER = RACE + 1 + RELAX;
    localparam int LAT = 1 + CFG + NT * PER + 1;

    logic           clk = 1'b0;
    logic           rst, start, busy, launch, resp_valid;
    logic [CHW-1:0] challenge, pdl_cfg;
    logic [DW-1:0]  latch_q, resp, unstable;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] pat [NTR];

    always #5 clk = ~clk;

    puf_race_ctrl #(
        .DATA_WIDTH (DW),
        .CHAL_WIDTH (CHW),
        .N_TRIALS   (NTR),
        .CFG_SETTLE (CFG),
        .RACE_WAIT  (RACE),
        .RELAX_WAIT (RELAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .challenge  (challenge),
        .busy       (busy),
        .pdl_cfg    (pdl_cfg),
        .launch     (launch),
        .latch_q    (latch_q),
        .resp       (resp),
        .unstable   (unstable),
        .resp_valid (resp_valid)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Majority over the trials actually raced: count ones per bit.
    function automatic void model(output logic [DW-1:0] r, output logic [DW-1:0] u);
        for (int b = 0; b < DW; b++) begin
            int ones;
            ones = 0;
            for (int t = 0; t < NT; t++) ones += int'(pat[t][b]);
            r[b] = (2 * ones > NT);
            u[b] = (ones != 0) && (ones != NT);
        end
    endfunction

    task automatic run_txn(input string tag, input logic [CHW-1:0] chal,
                           input logic [DW-1:0] er, input logic [DW-1:0] eu,
                           input int dup_at, input int rst_at);
        int bad_launch = 0, bad_busy = 0, n_valid = 0, valid_at = -1;
        int quiet_bad = 0;
        logic exp_launch;
        challenge = chal;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= LAT + 1; c++) begin
            exp_launch = (c >= 1 + CFG) && (c < 1 + CFG + NT * PER) && (((c - 1 - CFG) % PER) < RACE + 1);
            if (launch !== exp_launch) bad_launch++;
            if (busy !== (c <= LAT)) bad_busy++;
            if (resp_valid === 1'b1) begin
                n_valid++;
                if (valid_at < 0) valid_at = c;
            end
            if (c == LAT) begin
                check({tag, "_resp"}, resp, er);
                check({tag, "_unstable"}, unstable, eu);
                check({tag, "_pdl_cfg"}, pdl_cfg, chal);
            end
            if (c == LAT + 1) check({tag, "_resp_hold"}, resp, er);
            if (c >= 1 + CFG && (c - 1 - CFG) / PER < NT) latch_q = pat[(c - 1 - CFG) / PER];
            if (dup_at > 0 && c == dup_at) begin
                start     = 1'b1;
                challenge = ~chal;
            end
            if (dup_at > 0 && c == dup_at + 1) start = 1'b0;
            if (rst_at > 0 && c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check({tag, "_rst_ctl"}, {busy, launch, resp_valid}, 0);
                check({tag, "_rst_pdl"}, pdl_cfg, 0);
                check({tag, "_rst_resp"}, {resp, unstable}, 0);
                for (int q = 0; q < 40; q++) begin
                    @(posedge clk); #1;
                    if (resp_valid !== 1'b0 || launch !== 1'b0 || busy !== 1'b0) quiet_bad++;
                end
                check({tag, "_rst_quiet"}, quiet_bad, 0);
                return;
            end
            @(posedge clk); #1;
        end
        check({tag, "_launch_wave"}, bad_launch, 0);
        check({tag, "_busy_wave"}, bad_busy, 0);
        check({tag, "_valid_count"}, n_valid, 1);
        check({tag, "_valid_cycle"}, valid_at, LAT);
    endtask

    typedef struct {
        logic [CHW-1:0] chal;
        logic [DW-1:0]  lq;
        logic [DW-1:0]  exp_resp;
        logic [DW-1:0]  exp_unst;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [DW-1:0] er, eu, base, nmask;
        rst       = 1'b1;
        start     = 1'b0;
        challenge = '0;
        latch_q   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", {busy, launch, resp_valid}, 0);
        check("reset_pdl", pdl_cfg, 0);
        check("reset_resp", resp, 0);
        check("reset_unstable", unstable, 0);

        // Reset beats a simultaneous start.
        start     = 1'b1;
        challenge = 64'hDEAD_BEEF_0000_1111;
        @(posedge clk); #1;
        check("rst_vs_start_busy", busy, 0);
        check("rst_vs_start_pdl", pdl_cfg, 0);
        start = 1'b0;
        rst   = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{64'h1234_5678_9ABC_DEF0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 32'h0};
        vecs[1] = '{64'hFEDC_BA98_7654_3210, 32'hFFFF_0000, 32'hFFFF_0000, 32'h0};
        vecs[2] = '{64'h0000_0000_0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0};
        vecs[3] = '{64'h8000_0000_0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0};
        for (int v = 0; v < 4; v++) begin
            for (int t = 0; t < NTR; t++) pat[t] = vecs[v].lq;
            run_txn($sformatf("vec%0d", v), vecs[v].chal, vecs[v].exp_resp, vecs[v].exp_unst, 0, 0);
        end

        for (int r = 0; r < 6; r++) begin
            base  = $urandom;
            nmask = $urandom & $urandom;
            for (int t = 0; t < NTR; t++) pat[t] = base ^ ($urandom & nmask);
            model(er, eu);
            run_txn($sformatf("rand%0d", r), {$urandom, $urandom}, er, eu, 0, 0);
        end

        // Bit 0 high on 8 trials, bit 1 high on 7 trials.
        for (int t = 0; t < NTR; t++) begin
            pat[t]    = 32'hC3C3_3C3C;
            pat[t][0] = (t < 8);
            pat[t][1] = (t < 7);
        end
`ifdef PUF_MAJORITY_VOTE_EN
        run_txn("noisy", 64'h0F0F_F0F0_5555_AAAA, 32'hC3C3_3C3D, 32'h0000_0003, 0, 0);
`else
        run_txn("noisy", 64'h0F0F_F0F0_5555_AAAA, 32'hC3C3_3C3F, 32'h0000_0000, 0, 0);
`endif

        for (int t = 0; t < NTR; t++) pat[t] = 32'h1357_9BDF;
        run_txn("start_busy", 64'h1111_2222_3333_4444, 32'h1357_9BDF, 32'h0,
                (LAT > 60) ? 50 : 20, 0);

        run_txn("rst_mid", 64'h5555_6666_7777_8888, 32'h0, 32'h0, 0, (LAT > 110) ? 100 : 14);

        for (int t = 0; t < NTR; t++) pat[t] = 32'h2468_ACE0;
        run_txn("after_rst", 64'h9999_AAAA_BBBB_CCCC, 32'h2468_ACE0, 32'h0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
